// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states
// and the iteration count.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULDIV_MULT  = 3'd0,
        MULDIV_MULTU = 3'd1,
        MULDIV_DIV   = 3'd2,
        MULDIV_DIVU  = 3'd3,
        MULDIV_MTHI  = 3'd4,
        MULDIV_MTLO  = 3'd5
    } muldiv_op_e;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} muldiv_state_e;

    localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step on the {acc, operand} pair: right-shifting shift-add for
// multiply, restoring shift-subtract for divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier}
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        // Divide: acc = {remainder, dividend/quotient}; rem < divisor keeps diff in range
        trial = acc[2*WIDTH-1:WIDTH-1];
        diff  = trial - {1'b0, opnd};
        if (is_div) begin
            if (diff[WIDTH])
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning the HI/LO pair.
// MULDIV_EARLY_OUT_EN: multiplies stop once the remaining multiplier is zero.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(MULDIV_ITERS);

    muldiv_state_e      state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               is_arith;
    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic               last_step;
`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0]   mrem;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_next)
    );

    always_comb begin
        is_arith = (op == MULDIV_MULT) || (op == MULDIV_MULTU) ||
                   (op == MULDIV_DIV)  || (op == MULDIV_DIVU);
        sgn      = (op == MULDIV_MULT) || (op == MULDIV_DIV);
        a_neg    = sgn && a[WIDTH-1];
        b_neg    = sgn && b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        prod_fix = neg_q ? -acc : acc;
        q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_EARLY_OUT_EN
        last_step = (cnt == CW'(MULDIV_ITERS-1)) || (!is_div && (mrem >> 1) == '0);
`else
        last_step = (cnt == CW'(MULDIV_ITERS-1));
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
`ifdef MULDIV_EARLY_OUT_EN
            mrem        <= '0;
`endif
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && is_arith) begin
                        // Entering LOAD: magnitudes, signs, cleared acc, counter zero
                        state  <= LOAD;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op[1];
                        opnd   <= op[1] ? b_mag : a_mag;
                        acc    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
`ifdef MULDIV_EARLY_OUT_EN
                        mrem   <= b_mag;
`endif
                    end else if (start && op == MULDIV_MTHI) begin
                        hi <= a;
                    end else if (start && op == MULDIV_MTLO) begin
                        lo <= a;
                    end
                end
                LOAD, ITER: begin
                    if (state == LOAD && is_div && opnd == '0) begin
                        // Divide by zero: finish now, HI/LO untouched
                        state       <= IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                    end else begin
                        state <= last_step ? FIX : ITER;
                        cnt   <= cnt + 1'b1;
                        acc   <= acc_next;
`ifdef MULDIV_EARLY_OUT_EN
                        mrem  <= mrem >> 1;
                        // Realign the product for the steps that were skipped
                        if (last_step && !is_div)
                            acc <= acc_next >> (CW'(WIDTH-1) - cnt);
`endif
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed table, multi-cycle corner
// sequences, and random ops checked against an arithmetic reference model.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        bit          edbz;
        bit          edone;
    } vec_t;

    vec_t tbl[13];

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // Cycles from the start-sampling edge until done is observed.
    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] bv);
`ifdef MULDIV_EARLY_OUT_EN
        logic [31:0] m;
        int msb;
`endif
        if (o == 3'd2 || o == 3'd3) return (bv == 0) ? 1 : 33;
`ifdef MULDIV_EARLY_OUT_EN
        m = (o == 3'd0 && bv[31]) ? -bv : bv;
        msb = 0;
        for (int i = 0; i < 32; i++) if (m[i]) msb = i;
        return 2 + msb;
`else
        return 33;
`endif
    endfunction

    task automatic model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] ehi, output logic [31:0] elo,
                         output bit edbz, output bit edone);
        longint p, q, r;
        logic [63:0] u;
        ehi = mhi; elo = mlo; edbz = 0; edone = 1;
        case (o)
            3'd0: begin p = longint'($signed(av)) * longint'($signed(bv)); {ehi, elo} = p; end
            3'd1: begin u = {32'b0, av} * {32'b0, bv}; {ehi, elo} = u; end
            3'd2: if (bv == 0) edbz = 1;
                  else begin
                      q = longint'($signed(av)) / longint'($signed(bv));
                      r = longint'($signed(av)) % longint'($signed(bv));
                      elo = q[31:0]; ehi = r[31:0];
                  end
            3'd3: if (bv == 0) edbz = 1; else begin elo = av / bv; ehi = av % bv; end
            3'd4: begin ehi = av; edone = 0; end
            3'd5: begin elo = av; edone = 0; end
            default: edone = 0;
        endcase
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                          input bit edbz, input bit edone);
        int n;
        bit seen_idle;
        @(negedge clk); start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk); start = 1'b0;
        if (edone) begin
            chk({nm, ".busy0"}, busy, 1);
            n = 0; seen_idle = 0;
            while (!done && n < 100) begin
                @(negedge clk); n++;
                if (!done && !busy) seen_idle = 1;
            end
            chk({nm, ".lat"}, n, exp_lat(o, bv));
            chk({nm, ".busy_hold"}, seen_idle, 0);
            chk({nm, ".busy_end"}, busy, 0);
            chk({nm, ".dbz"}, div_by_zero, edbz);
        end else begin
            n = 0;
            repeat (3) begin
                if (done || busy || div_by_zero) n++;
                @(negedge clk);
            end
            chk({nm, ".quiet"}, n, 0);
        end
        chk({nm, ".hi"}, hi, ehi);
        chk({nm, ".lo"}, lo, elo);
        if (edone) begin
            @(negedge clk);
            chk({nm, ".pulse"}, done | div_by_zero, 0);
        end
        mhi = ehi; mlo = elo;
    endtask

    initial begin
        int n, pulses;
        logic [2:0]  ro;
        logic [31:0] ra, rb, ehi, elo;
        bit edbz, edone;

        tbl[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1};
        tbl[1]  = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 1};
        tbl[2]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 1};
        tbl[3]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1};
        tbl[4]  = '{3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 0, 1};
        tbl[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 1};
        tbl[6]  = '{3'd4, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'h8000_0000, 0, 0};
        tbl[7]  = '{3'd3, 32'h0000_0005, 32'h0000_0000, 32'h0000_1234, 32'h8000_0000, 1, 1};
        tbl[8]  = '{3'd1, 32'h0000_0009, 32'h0000_0005, 32'h0000_0000, 32'h0000_002D, 0, 1};
        tbl[9]  = '{3'd0, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1};
        tbl[10] = '{3'd5, 32'h0000_CAFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_CAFE, 0, 0};
        tbl[11] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 1};
        tbl[12] = '{3'd6, 32'h0000_BEEF, 32'h0000_0003, 32'h0000_0001, 32'hFFFF_FFFD, 0, 0};

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.dbz", div_by_zero, 0);
        chk("rst.hi", hi, 0);
        chk("rst.lo", lo, 0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].ehi, tbl[i].elo, tbl[i].edbz, tbl[i].edone);

        // Back-to-back: new start in the cycle done is high
        @(negedge clk); start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("b2b.lat1", n, 33);
        chk("b2b.lo1", lo, 14);
        chk("b2b.hi1", hi, 2);
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        @(negedge clk); start = 1'b0;
        chk("b2b.busy", busy, 1);
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("b2b.lat2", n, exp_lat(3'd1, 32'd4));
        chk("b2b.lo2", lo, 12);
        chk("b2b.hi2", hi, 0);
        mhi = 0; mlo = 12;

        // MTLO while busy must be dropped
        @(negedge clk); start = 1'b1; op = 3'd1; a = 32'd6; b = 32'h0007_0000;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'hDEAD;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("busyign.done", done, 1);
        chk("busyign.lo", lo, 32'h002A_0000);
        chk("busyign.hi", hi, 0);
        @(negedge clk);
        chk("busyign.lo_after", lo, 32'h002A_0000);
        mhi = 0; mlo = 32'h002A_0000;

        // Reset mid-iteration aborts with HI/LO cleared
        @(negedge clk); start = 1'b1; op = 3'd3; a = 32'h1234_5678; b = 32'd3;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.hi", hi, 0);
        chk("midrst.lo", lo, 0);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin @(negedge clk); if (done || busy) pulses++; end
        chk("midrst.quiet", pulses, 0);
        mhi = 0; mlo = 0;

        // Random ops against the reference model
        for (int k = 0; k < 40; k++) begin
            ro = 3'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000;
                1: ra = $urandom_range(0, 255);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = $urandom_range(0, 3);
                1: rb = $urandom_range(0, 255);
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            model(ro, ra, rb, ehi, elo, edbz, edone);
            run_op($sformatf("rnd%0d", k), ro, ra, rb, ehi, elo, edbz, edone);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
